// File: rtl/fetch_unit_if.sv
// Fetch sequencer bus: control request, instruction memory, IR/PC updates.
// Optional perf counters appear when FETCH_PERF_EN is defined.
interface fetch_unit_if;
  logic        Fetch_Req;
  logic [31:0] PC_In;
  logic [31:0] Mem_Data;
  logic [31:0] Mem_Addr;
  logic        Mem_Rd;
  logic [31:0] Instr;
  logic        IR_Write;
  logic [31:0] PC_Next;
  logic        PC_Load;
  logic        Busy;
  logic        Done;
  logic        Fault;
`ifdef FETCH_PERF_EN
  logic [31:0] Fetch_Count;
  logic [15:0] Fault_Count;
`endif

  modport slave (
    input  Fetch_Req, PC_In, Mem_Data,
    output Mem_Addr, Mem_Rd, Instr, IR_Write,
    output PC_Next, PC_Load, Busy, Done, Fault
`ifdef FETCH_PERF_EN
    , output Fetch_Count, Fault_Count
`endif
  );

  modport master (
    output Fetch_Req, PC_In, Mem_Data,
    input  Mem_Addr, Mem_Rd, Instr, IR_Write,
    input  PC_Next, PC_Load, Busy, Done, Fault
`ifdef FETCH_PERF_EN
    , input Fetch_Count, Fault_Count
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// Multicycle instruction fetch: IDLE -> READ x MEM_LAT -> CAPTURE.
// Misaligned PC goes to FAULT. Perf counters under FETCH_PERF_EN.
module fetch_unit #(
  parameter int unsigned MEM_LAT    = 3,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input logic        Clk,
  input logic        Reset,
  fetch_unit_if.slave bus
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_chk
    $error("fetch_unit: MEM_LAT must be 1..15");
  end

  typedef enum logic [1:0] {
    IDLE, READ, CAPTURE, FAULT
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] pc_next_q;
  logic        rd_q;
  logic        ir_we_q;
  logic        pc_ld_q;
  logic        busy_q;
  logic        done_q;
  logic        fault_q;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  // FSM with all outputs registered on the transition into each state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= RESET_ADDR;
      instr_q   <= '0;
      pc_next_q <= RESET_ADDR;
      rd_q      <= 1'b0;
      ir_we_q   <= 1'b0;
      pc_ld_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      ir_we_q <= 1'b0;
      pc_ld_q <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.Fetch_Req) begin
            busy_q <= 1'b1;
            if (bus.PC_In[1:0] == 2'b00) begin
              state_q <= READ;
              addr_q  <= bus.PC_In;
              cnt_q   <= LAT_M1;
              rd_q    <= 1'b1;
            end else begin
              state_q <= FAULT;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (cnt_q == 4'd0) begin
            state_q   <= CAPTURE;
            rd_q      <= 1'b0;
            instr_q   <= bus.Mem_Data;
            ir_we_q   <= 1'b1;
            pc_ld_q   <= 1'b1;
            done_q    <= 1'b1;
            pc_next_q <= addr_q + 32'd4;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        CAPTURE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        FAULT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] fault_cnt_q;

  // Count completed fetches and misaligned faults; both wrap
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_cnt_q <= '0;
      fault_cnt_q <= '0;
    end else begin
      if (state_q == CAPTURE)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == FAULT)
        fault_cnt_q <= fault_cnt_q + 16'd1;
    end
  end

  assign bus.Fetch_Count = fetch_cnt_q;
  assign bus.Fault_Count = fault_cnt_q;
`endif

  assign bus.Mem_Addr = addr_q;
  assign bus.Mem_Rd   = rd_q;
  assign bus.Instr    = instr_q;
  assign bus.IR_Write = ir_we_q;
  assign bus.PC_Next  = pc_next_q;
  assign bus.PC_Load  = pc_ld_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Fault    = fault_q;

endmodule
